// File: rtl/cp0.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : cp0
//  Purpose  : Coprocessor-0 interrupt/exception register block (SR, Cause,
//             EPC, PRId) with the interrupt request and mfc0 read port.
//  Revision : 1.0 - initial release
// ============================================================================
module cp0 #(
    parameter logic [31:0] PRID_VALUE = 32'h4D50_5334
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [31:0] PC,
    input  logic [5:0]  HWInt,
    input  logic        EXLSet,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    localparam logic [4:0] C_ADDR_SR    = 5'd12;
    localparam logic [4:0] C_ADDR_CAUSE = 5'd13;
    localparam logic [4:0] C_ADDR_EPC   = 5'd14;
    localparam logic [4:0] C_ADDR_PRID  = 5'd15;

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [29:0] r_epc;

    logic        w_we_sr;
    logic        w_we_epc;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic [31:0] w_epc;
    logic        w_unused_pc;

    assign w_we_sr     = We && (A2 == C_ADDR_SR);
    assign w_we_epc    = We && (A2 == C_ADDR_EPC);
    assign w_unused_pc = ^PC[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_im      <= 6'h0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_ip      <= 6'h0;
            r_exccode <= 5'h0;
            r_epc     <= 30'h0;
        end else begin
            r_ip <= HWInt;

            // IM/IE follow mtc0 even when an exception entry/return shares the cycle
            if (w_we_sr) begin
                r_im <= DIn[15:10];
                r_ie <= DIn[0];
            end

            if (EXLSet)
                r_exl <= 1'b1;
            else if (EXLClr)
                r_exl <= 1'b0;
            else if (w_we_sr)
                r_exl <= DIn[1];

            if (EXLSet) begin
                r_epc     <= PC[31:2];
                r_exccode <= 5'd0;
            end else if (w_we_epc) begin
                r_epc <= DIn[31:2];
            end
        end
    end

    assign w_sr    = {16'h0, r_im, 8'h0, r_exl, r_ie};
    assign w_cause = {16'h0, r_ip, 3'h0, r_exccode, 2'b00};
    assign w_epc   = {r_epc, 2'b00};

    assign IntReq = (|(HWInt & r_im)) & r_ie & ~r_exl;
    assign EPC    = w_epc;

    always_comb begin
        DOut = 32'h0;
        case (A1)
            C_ADDR_SR:    DOut = w_sr;
            C_ADDR_CAUSE: DOut = w_cause;
            C_ADDR_EPC:   DOut = w_epc;
            C_ADDR_PRID:  DOut = PRID_VALUE;
            default:      DOut = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cp0
//  Purpose  : Self-checking bench for cp0 (directed scenarios plus random
//             traffic against a register-level reference model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cp0;

    localparam logic [31:0] C_PRID = 32'h4D50_5334;

    logic        clk;
    logic        rst_n;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PC;
    logic [5:0]  HWInt;
    logic        EXLSet;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    int n_checks = 0;
    int n_fail   = 0;

    // architectural view of the registers as software would read them
    logic [31:0] m_sr    = 32'h0;
    logic [31:0] m_cause = 32'h0;
    logic [31:0] m_epc   = 32'h0;

    cp0 #(.PRID_VALUE(C_PRID)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A1     (A1),
        .A2     (A2),
        .DIn    (DIn),
        .We     (We),
        .PC     (PC),
        .HWInt  (HWInt),
        .EXLSet (EXLSet),
        .EXLClr (EXLClr),
        .IntReq (IntReq),
        .EPC    (EPC),
        .DOut   (DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return C_PRID;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_intreq();
        logic [5:0] im;
        im = m_sr[15:10];
        return ((HWInt & im) != 6'h0) && m_sr[0] && !m_sr[1];
    endfunction

    task automatic model_edge();
        logic [31:0] nsr;
        logic [31:0] nepc;
        nsr  = m_sr;
        nepc = m_epc;
        if (We && A2 == 5'd12) nsr = {16'h0, DIn[15:10], 8'h0, DIn[1], DIn[0]};
        if (EXLClr) nsr[1] = 1'b0;
        if (EXLSet) nsr[1] = 1'b1;
        if (We && A2 == 5'd14) nepc = {DIn[31:2], 2'b00};
        if (EXLSet) nepc = {PC[31:2], 2'b00};
        m_sr    = nsr;
        m_epc   = nepc;
        m_cause = {16'h0, HWInt, 10'h0};
    endtask

    task automatic apply(input logic rn, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] din, input logic we, input logic [31:0] pc,
                         input logic [5:0] hw, input logic set, input logic clr);
        rst_n = rn; A1 = a1; A2 = a2; DIn = din; We = we; PC = pc;
        HWInt = hw; EXLSet = set; EXLClr = clr;
        if (!rn) begin
            m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_intreq"}, {31'h0, IntReq}, {31'h0, model_intreq()});
        check_eq({tag, "_epc"}, EPC, m_epc);
        check_eq({tag, "_dout"}, DOut, model_read(A1));
    endtask

    initial begin
        // reset dominates writes and interrupt lines
        apply(1'b0, 5'd12, 5'd12, 32'hFFFF_FFFF, 1'b1, 32'h0000_1234, 6'h3F, 1'b1, 1'b0);
        check_eq("rst_intreq", {31'h0, IntReq}, 32'h0);
        check_eq("rst_epc", EPC, 32'h0);
        check_eq("rst_sr", DOut, 32'h0);
        A1 = 5'd15; #1;
        check_eq("rst_prid", DOut, C_PRID);
        tick();
        A1 = 5'd12; #1;
        check_eq("rst_hold_sr", DOut, 32'h0);
        A1 = 5'd13; #1;
        check_eq("rst_hold_cause", DOut, 32'h0);

        apply(1'b1, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        tick();

        // masking
        apply(1'b1, 5'd12, 5'd12, 32'h0000_0401, 1'b1, 32'h0, 6'h0, 1'b0, 1'b0);
        tick();
        apply(1'b1, 5'd12, 5'd0, 32'h0, 1'b0, 32'h0, 6'b000010, 1'b0, 1'b0);
        check_eq("mask_sr", DOut, 32'h0000_0401);
        check_eq("mask_off", {31'h0, IntReq}, 32'h0);
        apply(1'b1, 5'd13, 5'd0, 32'h0, 1'b0, 32'h0, 6'b000001, 1'b0, 1'b0);
        check_eq("mask_on", {31'h0, IntReq}, 32'h1);
        tick();
        check_eq("cause_ip", DOut, 32'h0000_0400);

        // exception entry
        apply(1'b1, 5'd12, 5'd0, 32'h0, 1'b0, 32'h0000_3010, 6'b000001, 1'b1, 1'b0);
        tick();
        apply(1'b1, 5'd12, 5'd0, 32'h0, 1'b0, 32'h0, 6'b000001, 1'b0, 1'b0);
        check_eq("entry_epc", EPC, 32'h0000_3010);
        check_eq("entry_exl", DOut & 32'h2, 32'h2);
        check_eq("entry_intreq", {31'h0, IntReq}, 32'h0);

        // eret
        apply(1'b1, 5'd12, 5'd0, 32'h0, 1'b0, 32'h0, 6'b000001, 1'b0, 1'b1);
        tick();
        apply(1'b1, 5'd12, 5'd0, 32'h0, 1'b0, 32'h0, 6'b000001, 1'b0, 1'b0);
        check_eq("ret_exl", DOut & 32'h2, 32'h0);
        check_eq("ret_intreq", {31'h0, IntReq}, 32'h1);
        check_eq("ret_epc", EPC, 32'h0000_3010);

        // EPC collision and plain mtc0
        apply(1'b1, 5'd14, 5'd14, 32'h0000_5003, 1'b1, 32'h0000_3020, 6'h0, 1'b1, 1'b0);
        tick();
        apply(1'b1, 5'd14, 5'd0, 32'h0, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        check_eq("coll_epc", EPC, 32'h0000_3020);
        apply(1'b1, 5'd14, 5'd14, 32'h0000_5003, 1'b1, 32'h0, 6'h0, 1'b0, 1'b0);
        tick();
        check_eq("mtc0_epc", EPC, 32'h0000_5000);
        check_eq("mtc0_epc_rd", DOut, 32'h0000_5000);

        // read during write returns the old SR
        apply(1'b1, 5'd12, 5'd12, 32'h0000_FC01, 1'b1, 32'h0, 6'h0, 1'b0, 1'b0);
        check_eq("rdw_old", DOut, m_sr);
        tick();
        check_eq("rdw_new", DOut, 32'h0000_FC01);

        // Cause/PRId writes ignored
        apply(1'b1, 5'd13, 5'd13, 32'hFFFF_FFFF, 1'b1, 32'h0, 6'h0, 1'b0, 1'b0);
        tick();
        check_eq("cause_ro", DOut, 32'h0);

        // reset mid-operation overrides entry and mtc0
        apply(1'b0, 5'd12, 5'd12, 32'h0000_FFFF, 1'b1, 32'h0000_4000, 6'h3F, 1'b1, 1'b0);
        check_eq("midrst_sr", DOut, 32'h0);
        check_eq("midrst_epc", EPC, 32'h0);
        tick();
        check_eq("midrst_hold", DOut, 32'h0);
        apply(1'b1, 5'd14, 5'd14, 32'h0000_1234, 1'b1, 32'h0, 6'h0, 1'b0, 1'b0);
        tick();
        check_eq("postrst_epc", EPC, 32'h0000_1234);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [4:0] a1, a2;
            logic rn;
            a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            rn = ($urandom_range(0, 49) != 0);
            apply(rn, a1, a2, $urandom, ($urandom_range(0, 2) == 0), $urandom,
                  6'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
            check_model("rnd");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
